uid_rom: RTL and testbench

UID_ROM -- requirements
Module: uid_rom

---
 rtl/uid_rom.sv | 64 ++++++
 tb/tb_uid_rom.sv | 115 +++++++++++
 2 files changed

// File: rtl/uid_rom.sv
// Fixed 8-user x 4-digit BCD password table with a registered read port.
// Dout updates only on the rising clk edge; rst clears the output, never the table.
module uid_rom (
    input  logic [4:0] Addr,
    input  logic       clk,
    output logic [3:0] Dout,
    input  logic       rst
);

    logic [3:0] w_digit;

    // Unknown address bits match no item and fall to the default, so X/Z reads give 0.
    always_comb begin
        w_digit = 4'h0;
        case (Addr)
            5'd0:    w_digit = 4'd1;
            5'd1:    w_digit = 4'd2;
            5'd2:    w_digit = 4'd3;
            5'd3:    w_digit = 4'd4;
            5'd4:    w_digit = 4'd5;
            5'd5:    w_digit = 4'd6;
            5'd6:    w_digit = 4'd7;
            5'd7:    w_digit = 4'd8;
            5'd8:    w_digit = 4'd9;
            5'd9:    w_digit = 4'd0;
            5'd10:   w_digit = 4'd1;
            5'd11:   w_digit = 4'd2;
            5'd12:   w_digit = 4'd3;
            5'd13:   w_digit = 4'd4;
            5'd14:   w_digit = 4'd5;
            5'd15:   w_digit = 4'd6;
            5'd16:   w_digit = 4'd7;
            5'd17:   w_digit = 4'd8;
            5'd18:   w_digit = 4'd9;
            5'd19:   w_digit = 4'd0;
            5'd20:   w_digit = 4'd0;
            5'd21:   w_digit = 4'd0;
            5'd22:   w_digit = 4'd0;
            5'd23:   w_digit = 4'd0;
            5'd24:   w_digit = 4'd9;
            5'd25:   w_digit = 4'd9;
            5'd26:   w_digit = 4'd9;
            5'd27:   w_digit = 4'd9;
            5'd28:   w_digit = 4'd2;
            5'd29:   w_digit = 4'd4;
            5'd30:   w_digit = 4'd6;
            5'd31:   w_digit = 4'd8;
            default: w_digit = 4'h0;
        endcase
    end

    logic [3:0] r_dout;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dout <= 4'h0;
        end else begin
            r_dout <= w_digit;
        end
    end

    assign Dout = r_dout;

endmodule

// File: tb/tb_uid_rom.sv
// Directed bench for uid_rom: reset, hold/sweep, latency, full table, mid-read reset.
// Inputs change on the falling edge; Dout is checked on the falling edge after each rising edge.
module tb_uid_rom;

    logic [4:0] Addr;
    logic       clk;
    logic [3:0] Dout;
    logic       rst;

    int checks;
    int errors;
    int exp_tab [32];

    uid_rom dut (
        .Addr (Addr),
        .clk  (clk),
        .Dout (Dout),
        .rst  (rst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        exp_tab = '{1, 2, 3, 4,  5, 6, 7, 8,  9, 0, 1, 2,  3, 4, 5, 6,
                    7, 8, 9, 0,  0, 0, 0, 0,  9, 9, 9, 9,  2, 4, 6, 8};
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        Addr   = 5'd5;
        @(negedge clk);

        // Reset held for two edges with a nonzero-entry address present
        tick();
        check("reset_edge1", Dout, 4'd0);
        tick();
        check("reset_edge2", Dout, 4'd0);
        rst = 1'b0;
        tick();
        check("reset_release", Dout, 4'd6);

        // Sweep 0..5, each held 8 edges
        for (int a = 0; a < 6; a++) begin
            Addr = 5'(a);
            for (int k = 0; k < 8; k++) begin
                tick();
                check($sformatf("sweep_a%0d_e%0d", a, k), Dout, 4'(a + 1));
            end
        end

        // Latency: a mid-cycle address change must not reach Dout before the edge
        Addr = 5'd8;
        tick();
        check("lat_addr8", Dout, 4'd9);
        Addr = 5'd9;
        #1;
        check("lat_midcycle", Dout, 4'd9);
        @(posedge clk);
        #1;
        check("lat_after_edge", Dout, 4'd0);
        @(negedge clk);

        // Full table in order
        for (int a = 0; a < 32; a++) begin
            Addr = 5'(a);
            tick();
            check($sformatf("table_a%0d", a), Dout, 4'(exp_tab[a]));
        end

        // Reset pulse while reading the last entry
        Addr = 5'd31;
        tick();
        check("mid_pre", Dout, 4'd8);
        rst = 1'b1;
        tick();
        check("mid_rst", Dout, 4'd0);
        rst = 1'b0;
        tick();
        check("mid_post", Dout, 4'd8);

        // Boundary entries
        Addr = 5'd20;
        tick();
        check("bnd_a20", Dout, 4'd0);
        Addr = 5'd27;
        tick();
        check("bnd_a27", Dout, 4'd9);
        Addr = 5'd16;
        tick();
        check("bnd_a16", Dout, 4'd7);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
